stack_xfer: RTL and testbench
=============================

Name: stack_xfer

Overview:
- Sequencer that performs 16-bit PUSH and POP transfers between the CPU register file and the memory bus, in Game Boy order.
- Acts as the initiator on the register file's port. It drives rn_in/rn_out/we/change16/inc and consumes the 16-bit read data.
- Used by the control unit for PUSH/POP/CALL/RET, so the main FSM does not sequence SP by hand.
- AF is not in the register file, so it is exchanged through dedicated side ports.

Parameters:
- SP_IDX, 3, register-file index of SP.
- AF_CODE, 5, pair code that selects the external AF port instead of the register file.

Ports:
- clock  in  1  system clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = PUSH, 1 = POP.
- pair  in  3  0 BC, 1 DE, 2 HL, 4 PC, 5 AF; any other code is illegal.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when start arrives with an illegal pair.
- rf_rn_out  out  5  register-file read select, FHRRR format.
- rf_rdata  in  16  register-file read data (combinational from rf_rn_out).
- rf_rn_in  out  5  register-file write select, FHRRR format.
- rf_wdata  out  8  register-file write byte.
- rf_we  out  1  register-file write enable.
- rf_change16  out  1  16-bit increment/decrement select.
- rf_inc  out  1  1 = increment, 0 = decrement.
- af_in  in  16  current AF value, used for PUSH AF.
- af_out  out  16  popped AF value; valid while af_load is high.
- af_load  out  1  one-cycle strobe that loads af_out into A/F.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion.

Behaviour:
- Reset (async, reset_n = 0):
  - State goes to IDLE.
  - All outputs go to 0, including rf_rn_out, rf_rn_in, mem_addr and af_out.
  - Internal latches (val, addr, lo, hi) clear to 0.
  - Reset mid-transfer aborts immediately. SP changes already committed are not undone.
- IDLE and start handling:
  - start with a legal pair latches op and pair and moves to the first state.
  - start with pair 3, 6 or 7 pulses err for one cycle and stays in IDLE.
  - start outside IDLE is ignored.
- Register-file port rules:
  - rf_we, rf_change16 and af_load are high for exactly one cycle in their states and 0 elsewhere.
  - rf_rn_out defaults to 0 and rf_rdata is ignored outside the RD states.
  - An SP decrement/increment cycle drives rf_rn_in = {1,0,SP_IDX}, rf_change16 = 1, rf_we = 1, and rf_inc = 0 (decrement) or 1 (increment).
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from entry into a MEM state until mem_ack is sampled high at a posedge.
  - The state advances on that edge, and mem_req is 0 in the following state.
  - mem_ack while mem_req is low is ignored.
  - There is no timeout; mem_ack in the same cycle as mem_req gives zero wait states.
- PUSH sequence (one cycle per step unless marked "until ack"):
  1. PU_RDPAIR: rf_rn_out = {1,0,pair}; latch val = rf_rdata, or val = af_in for AF.
  2. PU_DEC: SP decrement.
  3. PU_RDSP: rf_rn_out = {1,0,SP_IDX}; latch addr = rf_rdata.
  4. PU_WRHI (until ack): mem write of val[15:8] to addr.
  5. PU_DEC2: SP decrement; addr <= addr - 1.
  6. PU_WRLO (until ack): mem write of val[7:0] to addr.
  7. DONE.
- POP sequence:
  1. PO_RDSP: latch addr = SP.
  2. PO_RDLO (until ack): mem read at addr; latch lo = mem_rdata.
  3. PO_INC: SP increment; addr <= addr + 1.
  4. PO_RDHI (until ack): mem read at addr; latch hi = mem_rdata.
  5. PO_INC2: SP increment.
  6. PO_WRLO: rf_rn_in = {0,0,pair}, rf_wdata = lo, rf_we = 1.
  7. PO_WRHI: rf_rn_in = {0,1,pair}, rf_wdata = hi, rf_we = 1.
  8. DONE.
  - For AF, PO_WRLO and PO_WRHI do not assert rf_we. Instead PO_WRHI asserts af_load with af_out = {hi, lo}.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 in DONE; a start there is not accepted until IDLE.
- Latency with zero-wait memory: PUSH completes with done in cycle 7 after the accepting edge; POP in cycle 8.
- Address arithmetic is 16-bit and wraps: 0x0000 - 1 = 0xFFFF, 0xFFFF + 1 = 0x0000.

Decomposition:
- Shared package holds:
  - state enum;
  - pair codes (PAIR_BC = 0, PAIR_DE = 1, PAIR_HL = 2, PAIR_PC = 4, PAIR_AF = 5);
  - SP_IDX;
  - FHRRR field helpers (full, hi and index bit positions).
- One FSM module; no sub-module is needed.

Test Plan:
- PUSH DE, DE = 0x1234, SP = 0xFFFE, zero-wait memory -> writes 0x12 @ 0xFFFD then 0x34 @ 0xFFFC; two SP decrements, leaving SP = 0xFFFC; done in cycle 7; busy in cycles 1-6.
- POP HL, memory[0xC000] = 0xCD, [0xC001] = 0xAB, SP = 0xC000, ack after 2 wait cycles each -> HL writes: low byte 0xCD, then high byte 0xAB; SP ends at 0xC002; done in cycle 12.
- POP AF with bytes 0xF0 / 0x12 -> af_load pulses with af_out = 0x12F0; rf_we never high in the write-back states.
- PUSH BC with SP = 0x0000 -> writes @ 0xFFFF and 0xFFFE (wrap).
- start with pair = 3 -> err pulses for one cycle, busy stays 0, no mem_req; start asserted during busy -> ignored, and only one done occurs.
- reset_n driven low while in PU_WRHI with mem_req held -> all outputs 0 immediately; the next start runs a clean transfer.

Source files
------------

// File: rtl/stack_xfer_pkg.sv
// Shared types and constants for the PUSH/POP stack transfer sequencer.
// FHRRR select format: F = full 16-bit access, H = high byte, RRR = register index.
package stack_xfer_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PU_RDPAIR,
      S_PU_DEC,
      S_PU_RDSP,
      S_PU_WRHI,
      S_PU_DEC2,
      S_PU_WRLO,
      S_PO_RDSP,
      S_PO_RDLO,
      S_PO_INC,
      S_PO_RDHI,
      S_PO_INC2,
      S_PO_WRLO,
      S_PO_WRHI,
      S_DONE
   } state_t;

   localparam logic [2:0] PAIR_BC = 3'd0;
   localparam logic [2:0] PAIR_DE = 3'd1;
   localparam logic [2:0] PAIR_HL = 3'd2;
   localparam logic [2:0] PAIR_PC = 3'd4;
   localparam logic [2:0] PAIR_AF = 3'd5;

   localparam logic [2:0] SP_IDX = 3'd3;

   localparam int FHRRR_F_BIT   = 4;
   localparam int FHRRR_H_BIT   = 3;
   localparam int FHRRR_IDX_MSB = 2;

   function automatic logic [4:0] fhrrr(input logic full, input logic hi, input logic [2:0] idx);
      logic [4:0] v;
      v                      = 5'b00000;
      v[FHRRR_F_BIT]         = full;
      v[FHRRR_H_BIT]         = hi;
      v[FHRRR_IDX_MSB:0]     = idx;
      return v;
   endfunction

   function automatic logic pair_legal(input logic [2:0] p);
      logic ok;
      case (p)
         PAIR_BC, PAIR_DE, PAIR_HL, PAIR_PC, PAIR_AF: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/stack_xfer_if.sv
// Byte-wide memory bus used by the stack sequencer; the sequencer is the master.
interface stack_xfer_if;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/stack_xfer.sv
// 16-bit PUSH/POP sequencer between the register file and the memory bus (Game Boy order:
// PUSH writes high byte at SP-1 then low at SP-2; POP reads low then high).
module stack_xfer #(
   parameter logic [2:0] SP_IDX  = stack_xfer_pkg::SP_IDX,
   parameter logic [2:0] AF_CODE = stack_xfer_pkg::PAIR_AF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic                op,
   input  logic [2:0]          pair,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [4:0]          rf_rn_out,
   input  logic [15:0]         rf_rdata,
   output logic [4:0]          rf_rn_in,
   output logic [7:0]          rf_wdata,
   output logic                rf_we,
   output logic                rf_change16,
   output logic                rf_inc,
   input  logic [15:0]         af_in,
   output logic [15:0]         af_out,
   output logic                af_load,
   stack_xfer_if.master        mem
);
   import stack_xfer_pkg::*;

   state_t      r_state;
   logic [2:0]  r_pair;
   logic [15:0] r_val;
   logic [15:0] r_addr;
   logic [7:0]  r_lo;
   logic [7:0]  r_hi;

   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [4:0]  r_rf_rn_out;
   logic [4:0]  r_rf_rn_in;
   logic [7:0]  r_rf_wdata;
   logic        r_rf_we;
   logic        r_rf_change16;
   logic        r_rf_inc;
   logic [15:0] r_af_out;
   logic        r_af_load;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [15:0] r_mem_addr;
   logic [7:0]  r_mem_wdata;

   logic        w_pair_legal;
   logic        w_is_af;
   logic [4:0]  w_sp_sel;

   assign w_pair_legal = pair_legal(pair);
   assign w_is_af      = (r_pair == AF_CODE);
   assign w_sp_sel     = fhrrr(1'b1, 1'b0, SP_IDX);

   // Outputs are all registered and are set up on the edge that enters the state using them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_pair        <= 3'd0;
         r_val         <= 16'h0000;
         r_addr        <= 16'h0000;
         r_lo          <= 8'h00;
         r_hi          <= 8'h00;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_rf_rn_out   <= 5'b00000;
         r_rf_rn_in    <= 5'b00000;
         r_rf_wdata    <= 8'h00;
         r_rf_we       <= 1'b0;
         r_rf_change16 <= 1'b0;
         r_rf_inc      <= 1'b0;
         r_af_out      <= 16'h0000;
         r_af_load     <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= 16'h0000;
         r_mem_wdata   <= 8'h00;
      end else begin
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_rf_rn_out   <= 5'b00000;
         r_rf_rn_in    <= 5'b00000;
         r_rf_wdata    <= 8'h00;
         r_rf_we       <= 1'b0;
         r_rf_change16 <= 1'b0;
         r_rf_inc      <= 1'b0;
         r_af_out      <= 16'h0000;
         r_af_load     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && w_pair_legal) begin
                  r_pair <= pair;
                  r_busy <= 1'b1;
                  if (op == 1'b0) begin
                     r_state     <= S_PU_RDPAIR;
                     r_rf_rn_out <= fhrrr(1'b1, 1'b0, pair);
                  end else begin
                     r_state     <= S_PO_RDSP;
                     r_rf_rn_out <= w_sp_sel;
                  end
               end else if (start) begin
                  r_err <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PU_RDPAIR: begin
               r_val         <= w_is_af ? af_in : rf_rdata;
               r_state       <= S_PU_DEC;
               r_rf_rn_in    <= w_sp_sel;
               r_rf_change16 <= 1'b1;
               r_rf_we       <= 1'b1;
               r_rf_inc      <= 1'b0;
            end
            S_PU_DEC: begin
               r_state     <= S_PU_RDSP;
               r_rf_rn_out <= w_sp_sel;
            end
            S_PU_RDSP: begin
               r_addr      <= rf_rdata;
               r_state     <= S_PU_WRHI;
               r_mem_req   <= 1'b1;
               r_mem_we    <= 1'b1;
               r_mem_addr  <= rf_rdata;
               r_mem_wdata <= r_val[15:8];
            end
            S_PU_WRHI: begin
               if (mem.mem_ack) begin
                  r_mem_req     <= 1'b0;
                  r_mem_we      <= 1'b0;
                  r_mem_addr    <= 16'h0000;
                  r_mem_wdata   <= 8'h00;
                  r_addr        <= r_addr - 16'd1;
                  r_state       <= S_PU_DEC2;
                  r_rf_rn_in    <= w_sp_sel;
                  r_rf_change16 <= 1'b1;
                  r_rf_we       <= 1'b1;
                  r_rf_inc      <= 1'b0;
               end
            end
            S_PU_DEC2: begin
               r_state     <= S_PU_WRLO;
               r_mem_req   <= 1'b1;
               r_mem_we    <= 1'b1;
               r_mem_addr  <= r_addr;
               r_mem_wdata <= r_val[7:0];
            end
            S_PU_WRLO: begin
               if (mem.mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= 16'h0000;
                  r_mem_wdata <= 8'h00;
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            S_PO_RDSP: begin
               r_addr     <= rf_rdata;
               r_state    <= S_PO_RDLO;
               r_mem_req  <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= rf_rdata;
            end
            S_PO_RDLO: begin
               if (mem.mem_ack) begin
                  r_lo          <= mem.mem_rdata;
                  r_mem_req     <= 1'b0;
                  r_mem_addr    <= 16'h0000;
                  r_addr        <= r_addr + 16'd1;
                  r_state       <= S_PO_INC;
                  r_rf_rn_in    <= w_sp_sel;
                  r_rf_change16 <= 1'b1;
                  r_rf_we       <= 1'b1;
                  r_rf_inc      <= 1'b1;
               end
            end
            S_PO_INC: begin
               r_state    <= S_PO_RDHI;
               r_mem_req  <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= r_addr;
            end
            S_PO_RDHI: begin
               if (mem.mem_ack) begin
                  r_hi          <= mem.mem_rdata;
                  r_mem_req     <= 1'b0;
                  r_mem_addr    <= 16'h0000;
                  r_state       <= S_PO_INC2;
                  r_rf_rn_in    <= w_sp_sel;
                  r_rf_change16 <= 1'b1;
                  r_rf_we       <= 1'b1;
                  r_rf_inc      <= 1'b1;
               end
            end
            S_PO_INC2: begin
               r_state <= S_PO_WRLO;
               if (!w_is_af) begin
                  r_rf_rn_in <= fhrrr(1'b0, 1'b0, r_pair);
                  r_rf_wdata <= r_lo;
                  r_rf_we    <= 1'b1;
               end
            end
            S_PO_WRLO: begin
               r_state <= S_PO_WRHI;
               // AF lives outside the register file, so it is handed over as one 16-bit strobe.
               if (w_is_af) begin
                  r_af_load <= 1'b1;
                  r_af_out  <= {r_hi, r_lo};
               end else begin
                  r_rf_rn_in <= fhrrr(1'b0, 1'b1, r_pair);
                  r_rf_wdata <= r_hi;
                  r_rf_we    <= 1'b1;
               end
            end
            S_PO_WRHI: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_mem_req   <= 1'b0;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= 16'h0000;
               r_mem_wdata <= 8'h00;
            end
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign rf_rn_out     = r_rf_rn_out;
   assign rf_rn_in      = r_rf_rn_in;
   assign rf_wdata      = r_rf_wdata;
   assign rf_we         = r_rf_we;
   assign rf_change16   = r_rf_change16;
   assign rf_inc        = r_rf_inc;
   assign af_out        = r_af_out;
   assign af_load       = r_af_load;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_stack_xfer.sv
// Directed bench for stack_xfer: a behavioural register file and byte memory are updated
// once per cycle on the falling edge, where all DUT outputs are also sampled.
module tb_stack_xfer;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [2:0]  pair;
   logic        busy;
   logic        done;
   logic        err;
   logic [4:0]  rf_rn_out;
   logic [15:0] rf_rdata;
   logic [4:0]  rf_rn_in;
   logic [7:0]  rf_wdata;
   logic        rf_we;
   logic        rf_change16;
   logic        rf_inc;
   logic [15:0] af_in;
   logic [15:0] af_out;
   logic        af_load;

   stack_xfer_if mem_bus ();

   logic [15:0] rf      [0:7];
   logic [7:0]  mem_arr [0:65535];
   logic [15:0] mw_addr [0:63];
   logic [7:0]  mw_data [0:63];
   logic [4:0]  rw_sel  [0:63];
   logic [7:0]  rw_data [0:63];
   logic [15:0] af_val;
   int mw_n, rw_n, chg_n, af_n, done_n, err_n, busy_n, req_n;
   int waits, wcnt;
   int checks, failures;

   assign rf_rdata = rf[rf_rn_out[2:0]];

   always #5 clock = ~clock;

   stack_xfer #(.SP_IDX(3'd3), .AF_CODE(3'd5)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .pair        (pair),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .rf_rn_out   (rf_rn_out),
      .rf_rdata    (rf_rdata),
      .rf_rn_in    (rf_rn_in),
      .rf_wdata    (rf_wdata),
      .rf_we       (rf_we),
      .rf_change16 (rf_change16),
      .rf_inc      (rf_inc),
      .af_in       (af_in),
      .af_out      (af_out),
      .af_load     (af_load),
      .mem         (mem_bus)
   );

   // One clock cycle: memory responder, register-file model and event counters.
   task tick();
      @(negedge clock);
      if (mem_bus.mem_req) begin
         if (wcnt == waits) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
            if (mem_bus.mem_we) begin
               mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
               mw_addr[mw_n % 64] = mem_bus.mem_addr;
               mw_data[mw_n % 64] = mem_bus.mem_wdata;
               mw_n++;
            end
         end else begin
            mem_bus.mem_ack = 1'b0;
            wcnt++;
         end
         req_n++;
      end else begin
         mem_bus.mem_ack   = 1'b0;
         mem_bus.mem_rdata = 8'h00;
         wcnt = 0;
      end
      if (rf_we) begin
         if (rf_change16) begin
            if (rf_inc) rf[rf_rn_in[2:0]] = rf[rf_rn_in[2:0]] + 16'd1;
            else        rf[rf_rn_in[2:0]] = rf[rf_rn_in[2:0]] - 16'd1;
            chg_n++;
         end else begin
            if (rf_rn_in[3]) rf[rf_rn_in[2:0]][15:8] = rf_wdata;
            else             rf[rf_rn_in[2:0]][7:0]  = rf_wdata;
            rw_sel[rw_n % 64]  = rf_rn_in;
            rw_data[rw_n % 64] = rf_wdata;
            rw_n++;
         end
      end
      if (af_load) begin
         af_n++;
         af_val = af_out;
      end
      if (done) done_n++;
      if (err)  err_n++;
      if (busy) busy_n++;
   endtask

   // Issues one request and runs until done (or budget expiry), then one more cycle back to IDLE.
   task automatic run_xfer(input logic i_op, input logic [2:0] i_pair, input int budget,
                           output int done_cyc, output logic [31:0] busy_mask);
      start     = 1'b1;
      op        = i_op;
      pair      = i_pair;
      done_cyc  = -1;
      busy_mask = 32'h0000_0000;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (busy) busy_mask[c] = 1'b1;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({busy, done, err, rf_we, rf_change16, af_load, mem_bus.mem_req, mem_bus.mem_we} !== 8'h00) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 00000000",
                  {busy, done, err, rf_we, rf_change16, af_load, mem_bus.mem_req, mem_bus.mem_we});
      end
      checks++;
      if (mem_bus.mem_addr !== 16'h0000) begin
         failures++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_bus.mem_addr);
      end
      checks++;
      if ({rf_rn_out, rf_rn_in} !== 10'h000) begin
         failures++; $display("FAIL reset_rn: got %b/%b expected 00000/00000", rf_rn_out, rf_rn_in);
      end
      checks++;
      if (af_out !== 16'h0000) begin
         failures++; $display("FAIL reset_af_out: got %h expected 0000", af_out);
      end
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_push_de();
      int dc;
      logic [31:0] bm;
      int m0, c0, r0;
      rf[1] = 16'h1234;
      rf[3] = 16'hFFFE;
      waits = 0;
      m0 = mw_n; c0 = chg_n; r0 = rw_n;
      run_xfer(1'b0, 3'd1, 20, dc, bm);
      checks++;
      if (dc !== 7) begin failures++; $display("FAIL push_de_latency: got %0d expected 7", dc); end
      checks++;
      if (bm !== 32'h0000_007E) begin failures++; $display("FAIL push_de_busy: got %h expected 0000007e", bm); end
      checks++;
      if (mw_n - m0 !== 2) begin failures++; $display("FAIL push_de_nwrites: got %0d expected 2", mw_n - m0); end
      checks++;
      if ({mw_addr[m0 % 64], mw_data[m0 % 64]} !== 24'hFFFD12) begin
         failures++; $display("FAIL push_de_hi: got %h expected fffd12", {mw_addr[m0 % 64], mw_data[m0 % 64]});
      end
      checks++;
      if ({mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64]} !== 24'hFFFC34) begin
         failures++;
         $display("FAIL push_de_lo: got %h expected fffc34", {mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64]});
      end
      checks++;
      if (rf[3] !== 16'hFFFC) begin failures++; $display("FAIL push_de_sp: got %h expected fffc", rf[3]); end
      checks++;
      if ((chg_n - c0 !== 2) || (rw_n - r0 !== 0)) begin
         failures++; $display("FAIL push_de_rfops: got %0d/%0d expected 2/0", chg_n - c0, rw_n - r0);
      end
   endtask

   task automatic test_pop_hl();
      int dc;
      logic [31:0] bm;
      int r0;
      mem_arr[16'hC000] = 8'hCD;
      mem_arr[16'hC001] = 8'hAB;
      rf[2] = 16'h0000;
      rf[3] = 16'hC000;
      waits = 2;
      r0 = rw_n;
      run_xfer(1'b1, 3'd2, 30, dc, bm);
      checks++;
      if (dc !== 12) begin failures++; $display("FAIL pop_hl_latency: got %0d expected 12", dc); end
      checks++;
      if (rw_n - r0 !== 2) begin failures++; $display("FAIL pop_hl_nwrites: got %0d expected 2", rw_n - r0); end
      checks++;
      if ({rw_sel[r0 % 64], rw_data[r0 % 64]} !== {5'b00010, 8'hCD}) begin
         failures++; $display("FAIL pop_hl_lo: got %b/%h expected 00010/cd", rw_sel[r0 % 64], rw_data[r0 % 64]);
      end
      checks++;
      if ({rw_sel[(r0 + 1) % 64], rw_data[(r0 + 1) % 64]} !== {5'b01010, 8'hAB}) begin
         failures++;
         $display("FAIL pop_hl_hi: got %b/%h expected 01010/ab", rw_sel[(r0 + 1) % 64], rw_data[(r0 + 1) % 64]);
      end
      checks++;
      if ({rf[2], rf[3]} !== 32'hABCD_C002) begin
         failures++; $display("FAIL pop_hl_regs: got %h/%h expected abcd/c002", rf[2], rf[3]);
      end
   endtask

   task automatic test_pop_af();
      int dc;
      logic [31:0] bm;
      int a0, r0;
      mem_arr[16'hC002] = 8'hF0;
      mem_arr[16'hC003] = 8'h12;
      rf[3] = 16'hC002;
      waits = 1;
      a0 = af_n; r0 = rw_n;
      run_xfer(1'b1, 3'd5, 30, dc, bm);
      checks++;
      if (dc !== 10) begin failures++; $display("FAIL pop_af_latency: got %0d expected 10", dc); end
      checks++;
      if (af_n - a0 !== 1) begin failures++; $display("FAIL pop_af_loads: got %0d expected 1", af_n - a0); end
      checks++;
      if (af_val !== 16'h12F0) begin failures++; $display("FAIL pop_af_value: got %h expected 12f0", af_val); end
      checks++;
      if (rw_n - r0 !== 0) begin failures++; $display("FAIL pop_af_rf_we: got %0d expected 0", rw_n - r0); end
      checks++;
      if (rf[3] !== 16'hC004) begin failures++; $display("FAIL pop_af_sp: got %h expected c004", rf[3]); end
   endtask

   task automatic test_push_wrap();
      int dc;
      logic [31:0] bm;
      int m0;
      rf[0] = 16'hBEEF;
      rf[3] = 16'h0000;
      waits = 0;
      m0 = mw_n;
      run_xfer(1'b0, 3'd0, 20, dc, bm);
      checks++;
      if (dc !== 7) begin failures++; $display("FAIL wrap_latency: got %0d expected 7", dc); end
      checks++;
      if ({mw_addr[m0 % 64], mw_data[m0 % 64], mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64]} !== 48'hFFFFBE_FFFEEF) begin
         failures++;
         $display("FAIL wrap_writes: got %h@%h %h@%h expected be@ffff ef@fffe", mw_data[m0 % 64], mw_addr[m0 % 64],
                  mw_data[(m0 + 1) % 64], mw_addr[(m0 + 1) % 64]);
      end
      checks++;
      if (rf[3] !== 16'hFFFE) begin failures++; $display("FAIL wrap_sp: got %h expected fffe", rf[3]); end
   endtask

   task automatic test_illegal_start();
      int e0, b0, q0;
      logic e1, e2;
      e0 = err_n; b0 = busy_n; q0 = req_n;
      start = 1'b1;
      op    = 1'b0;
      pair  = 3'd3;
      tick();
      start = 1'b0;
      e1 = err;
      tick();
      e2 = err;
      tick();
      tick();
      checks++;
      if ({e1, e2} !== 2'b10) begin failures++; $display("FAIL illegal_err_pulse: got %b expected 10", {e1, e2}); end
      checks++;
      if (err_n - e0 !== 1) begin failures++; $display("FAIL illegal_err_count: got %0d expected 1", err_n - e0); end
      checks++;
      if ((busy_n - b0 !== 0) || (req_n - q0 !== 0)) begin
         failures++; $display("FAIL illegal_quiet: got busy=%0d req=%0d expected 0/0", busy_n - b0, req_n - q0);
      end
   endtask

   task automatic test_busy_start();
      int d0, e0, m0;
      rf[2] = 16'h5678;
      rf[3] = 16'h8000;
      waits = 0;
      d0 = done_n; e0 = err_n; m0 = mw_n;
      start = 1'b1;
      op    = 1'b0;
      pair  = 3'd2;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 2) begin
            op   = 1'b1;
            pair = 3'd3;
         end
         if (c == 5) start = 1'b0;
      end
      op   = 1'b0;
      pair = 3'd0;
      checks++;
      if (done_n - d0 !== 1) begin failures++; $display("FAIL busy_start_done: got %0d expected 1", done_n - d0); end
      checks++;
      if (err_n - e0 !== 0) begin failures++; $display("FAIL busy_start_err: got %0d expected 0", err_n - e0); end
      checks++;
      if ((mw_n - m0 !== 2) || ({mw_addr[m0 % 64], mw_data[m0 % 64]} !== 24'h7FFF56)) begin
         failures++;
         $display("FAIL busy_start_writes: got n=%0d first=%h@%h expected n=2 first=56@7fff", mw_n - m0,
                  mw_data[m0 % 64], mw_addr[m0 % 64]);
      end
   endtask

   task automatic test_reset_mid();
      int dc;
      logic [31:0] bm;
      int m0;
      rf[1] = 16'h1234;
      rf[3] = 16'hD000;
      waits = 1000;
      start = 1'b1;
      op    = 1'b0;
      pair  = 3'd1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start = 1'b0;
      end
      checks++;
      if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata} !== {1'b1, 1'b1, 16'hCFFF, 8'h12}) begin
         failures++;
         $display("FAIL mid_wrhi_hold: got req=%b we=%b addr=%h data=%h expected 1 1 cfff 12",
                  mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, rf_we, rf_change16, af_load, mem_bus.mem_req, mem_bus.mem_we,
           mem_bus.mem_addr, mem_bus.mem_wdata, rf_rn_out, rf_rn_in, af_out} !== 58'h0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got busy=%b req=%b addr=%h data=%h rn=%b/%b expected all zero",
                  busy, mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_wdata, rf_rn_out, rf_rn_in);
      end
      tick();
      reset_n = 1'b1;
      waits = 0;
      tick();
      checks++;
      if (rf[3] !== 16'hCFFF) begin failures++; $display("FAIL mid_sp_kept: got %h expected cfff", rf[3]); end
      m0 = mw_n;
      run_xfer(1'b0, 3'd1, 20, dc, bm);
      checks++;
      if (dc !== 7) begin failures++; $display("FAIL mid_clean_latency: got %0d expected 7", dc); end
      checks++;
      if ({mw_addr[m0 % 64], mw_data[m0 % 64], mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64]} !== 48'hCFFE12_CFFD34) begin
         failures++;
         $display("FAIL mid_clean_writes: got %h@%h %h@%h expected 12@cffe 34@cffd", mw_data[m0 % 64], mw_addr[m0 % 64],
                  mw_data[(m0 + 1) % 64], mw_addr[(m0 + 1) % 64]);
      end
      checks++;
      if (rf[3] !== 16'hCFFD) begin failures++; $display("FAIL mid_clean_sp: got %h expected cffd", rf[3]); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mw_n = 0; rw_n = 0; chg_n = 0; af_n = 0;
      done_n = 0; err_n = 0; busy_n = 0; req_n = 0;
      waits = 0;
      wcnt  = 0;
      af_val = 16'h0000;
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 1'b0;
      pair    = 3'd0;
      af_in   = 16'hA5C3;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 8'h00;
      for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

      test_reset();
      test_push_de();
      test_pop_hl();
      test_pop_af();
      test_push_wrap();
      test_illegal_start();
      test_busy_start();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
